// File: rtl/pipe_skid_buffer.sv
// pipe_skid_buffer: two-entry valid/ready pipeline stage with a skid register and a stall counter.
// in_ready depends only on registered state and flush, never on out_ready.
module pipe_skid_buffer #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [CNT_WIDTH-1:0]  stall_count
);
   typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_e;
   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] main_q, main_d, skid_q, skid_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic                  in_fire, out_fire;
   assign in_ready    = (state_q != FULL) & ~flush;
   assign out_valid   = (state_q != EMPTY) & ~flush;
   assign out_data    = main_q;
   assign stall_count = cnt_q;
   assign in_fire     = in_valid & in_ready;
   assign out_fire    = out_valid & out_ready;
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      cnt_d   = (out_valid & ~out_ready & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
      case (state_q)
         EMPTY: if (in_fire) begin
            main_d  = in_data;
            state_d = BUSY;
         end
         BUSY: begin
            if (in_fire & out_fire) main_d = in_data;
            else if (in_fire) begin
               skid_d  = in_data;
               state_d = FULL;
            end else if (out_fire) state_d = EMPTY;
         end
         FULL: if (out_fire) begin
            main_d  = skid_q;
            state_d = BUSY;
         end
         default: state_d = EMPTY;
      endcase
      // flush only empties the buffer; data and counter keep their values
      if (flush) state_d = EMPTY;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule

// File: tb/tb_pipe_skid_buffer.sv
// tb_pipe_skid_buffer: table vectors plus a queue scoreboard for pipe_skid_buffer.
module tb_pipe_skid_buffer;
   logic        clk = 0, reset_n = 1, flush = 0, in_valid = 0, out_ready = 0;
   logic [31:0] in_data = 0;
   logic        in_ready, out_valid, in_ready4, out_valid4;
   logic [31:0] out_data, out_data4;
   logic [15:0] stall_count;
   logic [3:0]  stall_count4;
   int          tests = 0, fails = 0;
   logic [31:0] mq[$];
   int          mcnt = 0, mcnt4 = 0;

   typedef struct {
      bit f; bit v; logic [31:0] d; bit r;
      bit eir; bit eov; logic [31:0] eod;
   } vec_t;

   pipe_skid_buffer #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
      .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .stall_count(stall_count));
   pipe_skid_buffer #(.DATA_WIDTH(32), .CNT_WIDTH(4)) dut4 (
      .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready4),
      .in_data(in_data), .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
      .stall_count(stall_count4));

   always #5 clk = ~clk;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // one clock: drive, compare against the queue model at negedge, advance the model at posedge
   task automatic cycle(input bit f, input bit v, input logic [31:0] d, input bit r,
                        output logic s_ir, output logic s_ov, output logic [31:0] s_od);
      bit m_ir, m_ov;
      flush = f; in_valid = v; in_data = d; out_ready = r;
      @(negedge clk);
      m_ir = (mq.size() < 2) && !f;
      m_ov = (mq.size() > 0) && !f;
      s_ir = in_ready; s_ov = out_valid; s_od = out_data;
      chk("in_ready", in_ready, m_ir);
      chk("out_valid", out_valid, m_ov);
      chk("in_ready4", in_ready4, m_ir);
      chk("out_valid4", out_valid4, m_ov);
      if (m_ov) chk("out_data", out_data, mq[0]);
      chk("stall_count", stall_count, mcnt);
      chk("stall_count4", stall_count4, mcnt4);
      out_ready = !r;
      #1 chk("in_ready_vs_out_ready", in_ready, m_ir);
      out_ready = r;
      #1;
      @(posedge clk);
      if (m_ov && !r) begin
         if (mcnt < 65535) mcnt++;
         if (mcnt4 < 15) mcnt4++;
      end
      if (f) mq.delete();
      else begin
         if (m_ov && r) void'(mq.pop_front());
         if (m_ir && v) mq.push_back(d);
      end
      #1;
   endtask

   task automatic step(input bit f, input bit v, input logic [31:0] d, input bit r);
      logic a, b;
      logic [31:0] c;
      cycle(f, v, d, r, a, b, c);
   endtask

   task automatic do_reset();
      flush = 0; in_valid = 0; out_ready = 0;
      @(posedge clk);
      #2 reset_n = 0;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_data", out_data, 0);
      chk("rst_stall_count", stall_count, 0);
      chk("rst_stall_count4", stall_count4, 0);
      mq.delete(); mcnt = 0; mcnt4 = 0;
      @(posedge clk);
      #2 reset_n = 1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t tbl[18];
      logic s_ir, s_ov;
      logic [31:0] s_od;
      tbl = '{
         '{0, 1, 32'h11, 1, 1, 0, 32'h0},
         '{0, 1, 32'h22, 1, 1, 1, 32'h11},
         '{0, 1, 32'h33, 1, 1, 1, 32'h22},
         '{0, 0, 32'h0,  1, 1, 1, 32'h33},
         '{0, 0, 32'h0,  1, 1, 0, 32'h0},
         '{0, 1, 32'hA0, 0, 1, 0, 32'h0},
         '{0, 1, 32'hA1, 0, 1, 1, 32'hA0},
         '{0, 0, 32'h0,  0, 0, 1, 32'hA0},
         '{0, 0, 32'h0,  1, 0, 1, 32'hA0},
         '{0, 0, 32'h0,  1, 1, 1, 32'hA1},
         '{0, 0, 32'h0,  1, 1, 0, 32'h0},
         '{0, 1, 32'hB0, 0, 1, 0, 32'h0},
         '{0, 1, 32'hB1, 0, 1, 1, 32'hB0},
         '{1, 1, 32'hB2, 1, 0, 0, 32'h0},
         '{0, 0, 32'h0,  1, 1, 0, 32'h0},
         '{0, 1, 32'hC0, 1, 1, 0, 32'h0},
         '{0, 0, 32'h0,  1, 1, 1, 32'hC0},
         '{0, 0, 32'h0,  1, 1, 0, 32'h0}
      };
      do_reset();
      foreach (tbl[i]) begin
         cycle(tbl[i].f, tbl[i].v, tbl[i].d, tbl[i].r, s_ir, s_ov, s_od);
         chk($sformatf("vec%0d_in_ready", i), s_ir, tbl[i].eir);
         chk($sformatf("vec%0d_out_valid", i), s_ov, tbl[i].eov);
         if (tbl[i].eov) chk($sformatf("vec%0d_out_data", i), s_od, tbl[i].eod);
      end
      chk("stall_after_table", stall_count, 3);
      // hold one word stalled for 20 cycles: the 4-bit counter pins at 15
      step(0, 1, 32'hD0, 0);
      for (int i = 0; i < 20; i++) step(0, 0, 0, 0);
      chk("sat4_reached", stall_count4, 15);
      chk("sat16_count", stall_count, 23);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
      chk("sat4_held", stall_count4, 15);
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      for (int i = 0; i < 10000; i++)
         step($urandom_range(0, 31) == 0, 1'($urandom), $urandom, 1'($urandom));
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      step(0, 1, 32'hE0, 0);
      step(0, 1, 32'hE1, 0);
      do_reset();
      step(0, 1, 32'hE2, 1);
      cycle(0, 0, 0, 1, s_ir, s_ov, s_od);
      chk("post_reset_out_valid", s_ov, 1);
      chk("post_reset_out_data", s_od, 32'hE2);
      step(0, 0, 0, 1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/pipe_skid_buffer.md
# pipe_skid_buffer

Two-entry registered pipeline stage with a valid/ready handshake on both sides. It is the flow-controlled counterpart to the plain per-cycle data register: it accepts a word from an upstream stage and holds it until the downstream stage takes it. When downstream stalls it absorbs one extra in-flight word, so upstream `in_ready` never depends combinationally on `out_ready`. It sits between CPU pipeline stages (e.g. fetch→decode, execute→memory) where a stage can stall or be flushed by a branch or exception.

## Interface
- `DATA_WIDTH`, 32, width of the data path.
- `CNT_WIDTH`, 16, width of the stall counter.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous discard of all held words.
- `in_valid`  in  1  upstream word present.
- `in_ready`  out  1  buffer can accept a word.
- `in_data`  in  DATA_WIDTH  upstream word.
- `out_valid`  out  1  word available to downstream.
- `out_ready`  in  1  downstream accepts the word.
- `out_data`  out  DATA_WIDTH  word presented downstream.
- `stall_count`  out  CNT_WIDTH  saturating count of stalled cycles.

## Operation
- Storage: main register (drives `out_data`), skid register, 2-bit state.
- States: EMPTY (0 words), BUSY (main valid), FULL (main and skid valid).
- Handshake events: `in_fire = in_valid & in_ready`; `out_fire = out_valid & out_ready`.
- `in_ready = (state != FULL) & ~flush`.
- `out_valid = (state != EMPTY) & ~flush`.
- EMPTY:
  - `in_fire` → main <= `in_data`, go to BUSY.
  - Otherwise stay in EMPTY.
- BUSY:
  - `in_fire & out_fire` → main <= `in_data`, stay in BUSY.
  - `in_fire & ~out_fire` → skid <= `in_data`, go to FULL.
  - `~in_fire & out_fire` → go to EMPTY.
  - Neither → hold.
- FULL (`in_ready` = 0):
  - `out_fire` → main <= skid, go to BUSY.
  - Otherwise hold.
- `flush` has the highest priority:
  - Next state is EMPTY.
  - No handshake completes in the flush cycle, because both `in_ready` and `out_valid` are forced low.
  - Data registers and `stall_count` are not cleared.
- Ordering: words leave in exactly the order they were accepted. No duplication, no loss except by flush.
- `stall_count` increments by 1 on each cycle where `out_valid & ~out_ready`. It saturates at all-ones and does not wrap.
- `out_data` keeps its last value in EMPTY; it is don't-care to downstream while `out_valid` = 0.

## Timing
- Reset (`reset_n` low, asynchronous):
  - state = EMPTY, main = 0, skid = 0, `stall_count` = 0.
  - Hence `out_valid` = 0, `out_data` = 0, `in_ready` = 1 (with `flush` low).
- Reset mid-transfer drops any held words immediately. The first edge after release behaves as EMPTY.
- Latency: a word accepted at edge N is visible on `out_data` with `out_valid` = 1 after edge N. That is 1 cycle from EMPTY.
- Throughput: 1 word/cycle sustained while `out_ready` = 1.
- `in_ready` is a function of registered state and `flush` only. It has no path from `out_ready`.
- After a stall releases in FULL, `in_ready` returns high one cycle after the `out_fire` edge.
- Simultaneous flush with `in_valid` / `out_ready` high: neither side fires. The buffer is EMPTY next cycle.

## Test plan
- **Reset defaults:** assert `reset_n` = 0 mid-cycle → immediately `out_valid` = 0, `in_ready` = 1, `out_data` = 0, `stall_count` = 0.
- **Streaming:** `out_ready` = 1, push 0x11, 0x22, 0x33 on consecutive cycles → same values appear on consecutive cycles, each 1 cycle later; state never reaches FULL.
- **Stall and fill:** push 0xA0, 0xA1 with `out_ready` = 0 → `in_ready` = 0 and `out_data` = 0xA0. Then set `out_ready` = 1 → 0xA0 then 0xA1 are delivered in order, and `stall_count` equals the number of stalled cycles.
- **Flush while FULL:** with 0xB0, 0xB1 held, pulse `flush` with `in_valid` = 1 and data 0xB2 → `out_valid` = 0 that cycle and next. 0xB2 is not accepted; the next pushed word is the next one out.
- **Counter saturation:** with `CNT_WIDTH` = 4, hold `out_ready` = 0 with a word present for 20 cycles → `stall_count` = 15 and stays there.
- **Randomized soak:** random `in_valid` / `out_ready` over 10k cycles against a queue model → output sequence matches exactly, and `in_ready` never depends on same-cycle `out_ready`.
